// File: rtl/aes256_key_share_loader.sv
// Collects a 256-bit key word by word and splits it into three Boolean shares
// (k0 = key ^ k1 ^ k2), then holds the shares until downstream takes them.
module aes256_key_share_loader #(
    parameter int ZEROIZE_ON_HANDOFF = 1,
    parameter int KEY_WORDS          = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         abort_i,
    input  logic [31:0]  key_word_i,
    input  logic         key_wvalid_i,
    output logic         key_wready_o,
    input  logic [63:0]  rnd_i,
    input  logic         rnd_valid_i,
    output logic         rnd_ready_o,
    output logic [255:0] k0_o,
    output logic [255:0] k1_o,
    output logic [255:0] k2_o,
    output logic         kvalid_o,
    input  logic         kready_i,
    output logic         busy_o
);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    state_t         r_state, w_state_next;
    logic [2:0]     r_cnt, w_cnt_next;
    logic           r_kvalid, w_kvalid_next;
    logic [255:0]   r_k0, r_k1, r_k2;
    logic [255:0]   w_k0_next, w_k1_next, w_k2_next;
    logic           w_accept;
    logic           w_handoff;
    logic           w_clear;
    logic [31:0]    w_m1;
    logic [31:0]    w_m2;

    assign w_m1      = rnd_i[31:0];
    assign w_m2      = rnd_i[63:32];
    // Key and randomness are consumed only as a pair, and never during abort.
    assign w_accept  = (r_state == ST_COLLECT) & key_wvalid_i & rnd_valid_i & ~abort_i;
    assign w_handoff = (r_state == ST_HOLD) & r_kvalid & kready_i;
    assign w_clear   = abort_i | (w_handoff & (ZEROIZE_ON_HANDOFF != 0));

    generate
        for (genvar gi = 0; gi < KEY_WORDS; gi++) begin : g_word
            localparam int HI = 255 - 32 * gi;
            logic w_sel;
            assign w_sel = w_accept & (r_cnt == 3'(gi));
            assign w_k0_next[HI -: 32] = w_clear ? 32'd0 :
                                         w_sel   ? (key_word_i ^ w_m1 ^ w_m2) : r_k0[HI -: 32];
            assign w_k1_next[HI -: 32] = w_clear ? 32'd0 :
                                         w_sel   ? w_m1 : r_k1[HI -: 32];
            assign w_k2_next[HI -: 32] = w_clear ? 32'd0 :
                                         w_sel   ? w_m2 : r_k2[HI -: 32];
        end
    endgenerate

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_kvalid_next = r_kvalid;
        if (abort_i) begin
            w_state_next  = ST_COLLECT;
            w_cnt_next    = 3'd0;
            w_kvalid_next = 1'b0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (w_accept) begin
                        if (r_cnt == 3'(KEY_WORDS - 1)) begin
                            w_cnt_next    = 3'd0;
                            w_state_next  = ST_HOLD;
                            w_kvalid_next = 1'b1;
                        end else begin
                            w_cnt_next = r_cnt + 3'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_handoff) begin
                        w_state_next  = ST_COLLECT;
                        w_kvalid_next = 1'b0;
                    end
                end
                default: begin
                    w_state_next  = ST_COLLECT;
                    w_cnt_next    = 3'd0;
                    w_kvalid_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_COLLECT;
            r_cnt    <= 3'd0;
            r_kvalid <= 1'b0;
            r_k0     <= '0;
            r_k1     <= '0;
            r_k2     <= '0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_kvalid <= w_kvalid_next;
            r_k0     <= w_k0_next;
            r_k1     <= w_k1_next;
            r_k2     <= w_k2_next;
        end
    end

    assign key_wready_o = w_accept;
    assign rnd_ready_o  = w_accept;
    assign k0_o         = r_k0;
    assign k1_o         = r_k1;
    assign k2_o         = r_k2;
    assign kvalid_o     = r_kvalid;
    assign busy_o       = (r_cnt != 3'd0) | (r_state == ST_HOLD);

endmodule
